// File: rtl/prbs_multi_checker.sv
// Self-synchronising multi-polynomial PRBS checker with lock FSM and saturating error counters.
// Optional macro PRBS_CHECKER_INJECT_EN adds inject_err, which inverts the oldest bit of a word.
module prbs_multi_checker #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 64,
  parameter int unsigned LOCK_COUNT  = 16,
  parameter int unsigned UNLOCK_ERRS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            mode,
`ifdef PRBS_CHECKER_INJECT_EN
  input  logic                  inject_err,
`endif
  output logic                  locked,
  output logic                  err_word,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [15:0]           lock_loss_count
);

  localparam int unsigned HistW = 31;
  localparam int unsigned FullW = DATA_WIDTH + HistW;
  localparam int unsigned PopW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned HuntW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BadW  = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e                state_q;
  logic [HistW-1:0]      hist_q;
  logic [4:0]            fill_q;
  logic [1:0]            mode_q;
  logic                  chk_q;
  logic [DATA_WIDTH-1:0] err_vec_q;
  logic [PopW-1:0]       pop_q;
  logic                  add_q;
  logic                  err_word_q;
  logic [HuntW-1:0]      hunt_q;
  logic [BadW-1:0]       bad_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;
  logic [15:0]           loss_q;

  logic                  mode_chg;
  logic [DATA_WIDTH-1:0] word;
  logic [HistW-1:0]      hist_src;
  logic [4:0]            fill_src;
  logic [FullW-1:0]      full;
  logic [DATA_WIDTH-1:0] pred;
  logic [DATA_WIDTH-1:0] err_vec_d;
  logic [6:0]            fill_sum;
  logic [4:0]            fill_d;
  logic                  checked;
  logic [PopW-1:0]       pop_d;
  logic                  word_err;
  logic [CNT_WIDTH:0]    cnt_sum;

  assign mode_chg = (mode != mode_q);

  always_comb begin
    word = data_in;
`ifdef PRBS_CHECKER_INJECT_EN
    word[DATA_WIDTH-1] = data_in[DATA_WIDTH-1] ^ (inject_err & valid_in);
`endif
  end

  // A mode change flushes the history, so the coincident word only starts a new fill.
  assign hist_src = mode_chg ? '0 : hist_q;
  assign fill_src = mode_chg ? '0 : fill_q;
  assign full     = {hist_src, word};
  assign checked  = (fill_src == 5'd31);
  assign fill_sum = 7'(fill_src) + 7'(DATA_WIDTH);
  assign fill_d   = (fill_sum >= 7'd31) ? 5'd31 : fill_sum[4:0];

  // full[k] is one bit newer than full[k+1]; each bit is predicted from bits p and q older.
  always_comb begin
    pred = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      case (mode)
        2'b00:   pred[j] = full[j+7]  ^ full[j+6];
        2'b01:   pred[j] = full[j+15] ^ full[j+14];
        2'b10:   pred[j] = full[j+23] ^ full[j+18];
        default: pred[j] = full[j+31] ^ full[j+28];
      endcase
    end
  end

  assign err_vec_d = word ^ pred;

  always_comb begin
    pop_d = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      pop_d = pop_d + PopW'(err_vec_q[j]);
    end
  end

  assign word_err = |err_vec_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q    <= '0;
      fill_q    <= '0;
      chk_q     <= 1'b0;
      err_vec_q <= '0;
      mode_q    <= mode;
    end else begin
      mode_q <= mode;
      chk_q  <= valid_in && checked;
      if (valid_in) begin
        err_vec_q <= err_vec_d;
        hist_q    <= full[HistW-1:0];
        fill_q    <= fill_d;
      end else if (mode_chg) begin
        hist_q <= '0;
        fill_q <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StHunt;
      hunt_q     <= '0;
      bad_q      <= '0;
      err_word_q <= 1'b0;
      add_q      <= 1'b0;
      pop_q      <= '0;
      loss_q     <= '0;
    end else begin
      err_word_q <= 1'b0;
      add_q      <= 1'b0;
      pop_q      <= pop_d;
      if (clear) loss_q <= '0;
      if (mode_chg) begin
        state_q <= StHunt;
        hunt_q  <= '0;
        bad_q   <= '0;
      end else if (chk_q) begin
        case (state_q)
          StHunt: begin
            if (word_err) begin
              hunt_q <= '0;
            end else if (hunt_q == HuntW'(LOCK_COUNT - 1)) begin
              state_q <= StLocked;
              hunt_q  <= '0;
              bad_q   <= '0;
            end else begin
              hunt_q <= hunt_q + 1'b1;
            end
          end
          StLocked: begin
            if (word_err) begin
              err_word_q <= 1'b1;
              add_q      <= 1'b1;
              if (bad_q == BadW'(UNLOCK_ERRS - 1)) begin
                state_q <= StHunt;
                hunt_q  <= '0;
                bad_q   <= '0;
                if (!clear && loss_q != 16'hFFFF) loss_q <= loss_q + 16'd1;
              end else begin
                bad_q <= bad_q + 1'b1;
              end
            end else begin
              bad_q <= '0;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  assign cnt_sum = {1'b0, err_cnt_q} + (CNT_WIDTH + 1)'(pop_q);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      err_cnt_q <= '0;
    end else if (add_q && !mode_chg) begin
      err_cnt_q <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end
  end

  assign locked          = (state_q == StLocked);
  assign err_word        = err_word_q;
  assign error_count     = err_cnt_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_prbs_multi_checker.sv
// Directed bench for prbs_multi_checker: bit-serial reference model feeds a scoreboard queue.
module tb_prbs_multi_checker;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned LC = 16;
  localparam int unsigned UE = 4;

  logic          clock = 1'b0;
  logic          reset, clear, valid_in;
  logic [W-1:0]  data_in;
  logic [1:0]    mode;
  logic          locked, err_word;
  logic [CW-1:0] error_count;
  logic [15:0]   lock_loss_count;
`ifdef PRBS_CHECKER_INJECT_EN
  logic          inject_err;
  assign inject_err = 1'b0;
`endif

  prbs_multi_checker #(
    .DATA_WIDTH (W),
    .CNT_WIDTH  (CW),
    .LOCK_COUNT (LC),
    .UNLOCK_ERRS(UE)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .clear          (clear),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .mode           (mode),
`ifdef PRBS_CHECKER_INJECT_EN
    .inject_err     (inject_err),
`endif
    .locked         (locked),
    .err_word       (err_word),
    .error_count    (error_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            due;
    bit            kind;
    logic          ew;
    logic          lk;
    logic [15:0]   llc;
    logic [CW-1:0] ec;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          tp, tq;
  logic [30:0] g;
  logic [30:0] mh;
  int          mfill, m_hunt, m_bad, m_ec, m_loss;
  bit          m_lk;
  logic [W-1:0] w;
  logic [W-1:0] msb_flip;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_taps(input logic [1:0] m);
    case (m)
      2'b00:   begin tp = 7;  tq = 6;  end
      2'b01:   begin tp = 15; tq = 14; end
      2'b10:   begin tp = 23; tq = 18; end
      default: begin tp = 31; tq = 28; end
    endcase
  endtask

  task automatic model_flush();
    mh = '0; mfill = 0; m_lk = 0; m_hunt = 0; m_bad = 0;
  endtask

  task automatic next_word(output logic [W-1:0] o);
    logic [30:0] t;
    o = '0;
    for (int i = 0; i < W; i++) begin
      t = (g >> (tp - 1)) ^ (g >> (tq - 1));
      g = {g[29:0], t[0]};
      o = {o[W-2:0], t[0]};
    end
  endtask

  // Bit-serial checker model; pushes expected outputs for N+1 and error_count for N+2.
  task automatic model_word(input logic [W-1:0] x, input bit push);
    logic [W-1:0] ww;
    logic [30:0]  t;
    bit           b, chkd, ew;
    int           errs;
    chkd = (mfill >= 31); errs = 0; ww = x; ew = 0;
    for (int i = 0; i < W; i++) begin
      b  = ww[W-1];
      ww = ww << 1;
      t  = (mh >> (tp - 1)) ^ (mh >> (tq - 1));
      if (b != t[0]) errs++;
      mh = {mh[29:0], b};
    end
    mfill = (mfill + W > 31) ? 31 : mfill + W;
    if (chkd) begin
      if (m_lk) begin
        if (errs > 0) begin
          ew = 1;
          m_ec = (m_ec + errs > 255) ? 255 : m_ec + errs;
          m_bad++;
          if (m_bad == UE) begin
            m_lk = 0; m_hunt = 0; m_bad = 0;
            if (m_loss < 65535) m_loss++;
          end
        end else m_bad = 0;
      end else if (errs > 0) m_hunt = 0;
      else begin
        m_hunt++;
        if (m_hunt == LC) begin m_lk = 1; m_hunt = 0; m_bad = 0; end
      end
    end
    if (push) begin
      sb.push_back('{cyc + 2, 1'b0, ew, m_lk, 16'(m_loss), '0});
      sb.push_back('{cyc + 3, 1'b1, 1'b0, 1'b0, 16'h0, CW'(m_ec)});
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clock);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.kind == 1'b0) begin
        chk("err_word", 64'(err_word), 64'(e.ew));
        chk("locked", 64'(locked), 64'(e.lk));
        chk("lock_loss_count", 64'(lock_loss_count), 64'(e.llc));
      end else begin
        chk("error_count", 64'(error_count), 64'(e.ec));
      end
    end
  endtask

  task automatic send(input logic [W-1:0] x, input bit push);
    valid_in = 1'b1; data_in = x;
    model_word(x, push);
    step();
  endtask

  task automatic gap();
    valid_in = 1'b0; data_in = $urandom;
    step();
  endtask

  task automatic drain();
    repeat (3) gap();
  endtask

  task automatic clean(input int n, input int gap_pct);
    logic [W-1:0] x;
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(99) < gap_pct) gap();
      next_word(x);
      send(x, 1'b1);
    end
  endtask

  task automatic garbage(input int n);
    logic [W-1:0] x;
    for (int k = 0; k < n; k++) begin
      next_word(x);
      send('1, 1'b1);
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m; set_taps(m); g = 31'h1; model_flush();
    gap();
  endtask

  initial begin
    msb_flip = '0; msb_flip[W-1] = 1'b1;
    reset = 1'b1; clear = 1'b0; valid_in = 1'b0; data_in = '0; mode = 2'b11;
    set_taps(2'b11); g = 31'h1; model_flush(); m_ec = 0; m_loss = 0;
    repeat (2) step();
    reset = 1'b0;
    chk("reset_locked", 64'(locked), 64'd0);
    chk("reset_err_word", 64'(err_word), 64'd0);
    chk("reset_error_count", 64'(error_count), 64'd0);
    chk("reset_lock_loss", 64'(lock_loss_count), 64'd0);

    // Fill word plus LOCK_COUNT clean words, then a long clean run.
    clean(17, 0);
    gap();
    chk("lock_after_fill_plus_16", 64'(locked), 64'd1);
    clean(2000, 0);
    drain();
    chk("clean_prbs31_errors", 64'(error_count), 64'd0);

    // Single flip of the oldest bit: flip, +28 and +31 all land in the same word.
    next_word(w);
    send(w ^ msb_flip, 1'b1);
    clean(5, 0);
    drain();
    chk("single_flip_count", 64'(error_count), 64'd3);
    chk("single_flip_locked", 64'(locked), 64'd1);

    garbage(4);
    gap();
    chk("garbage_unlock", 64'(locked), 64'd0);
    chk("garbage_loss", 64'(lock_loss_count), 64'd1);
    clean(40, 0);
    drain();
    chk("relock", 64'(locked), 64'd1);

    clear = 1'b1; gap(); clear = 1'b0;
    m_ec = 0; m_loss = 0;
    chk("clear_error_count", 64'(error_count), 64'd0);
    chk("clear_lock_loss", 64'(lock_loss_count), 64'd0);
    chk("clear_keeps_lock", 64'(locked), 64'd1);

    // Clear coincident with the increment of an errored word discards it.
    next_word(w); send(w ^ msb_flip, 1'b0);
    next_word(w); send(w, 1'b0);
    clear = 1'b1;
    next_word(w); send(w, 1'b0);
    clear = 1'b0;
    m_ec = 0;
    chk("clear_discards_inflight", 64'(error_count), 64'd0);
    gap();
    chk("clear_discards_after", 64'(error_count), 64'd0);
    drain();

    // Saturation: bursts of three errored words keep lock but overflow an 8-bit counter.
    for (int k = 0; k < 10; k++) begin
      garbage(2);
      clean(3, 0);
    end
    drain();
    chk("saturate_255", 64'(error_count), 64'd255);
    chk("saturate_locked", 64'(locked), 64'd1);
    clear = 1'b1; gap(); clear = 1'b0;
    m_ec = 0; m_loss = 0;
    chk("sat_clear", 64'(error_count), 64'd0);
    chk("sat_clear_locked", 64'(locked), 64'd1);

    // Mode change right behind an errored locked word: lock drops and the word is discarded.
    next_word(w);
    valid_in = 1'b1; data_in = w ^ msb_flip;
    step();
    mode = 2'b00; set_taps(2'b00); g = 31'h1; model_flush();
    gap();
    chk("mode_chg_unlock", 64'(locked), 64'd0);
    chk("mode_chg_no_pulse", 64'(err_word), 64'd0);
    chk("mode_chg_loss", 64'(lock_loss_count), 64'd0);
    gap();
    chk("mode_chg_count", 64'(error_count), 64'd0);

    clean(60, 30);
    drain();
    chk("prbs7_locked", 64'(locked), 64'd1);
    chk("prbs7_errors", 64'(error_count), 64'd0);
    set_mode(2'b01);
    clean(60, 30);
    drain();
    chk("prbs15_locked", 64'(locked), 64'd1);
    chk("prbs15_errors", 64'(error_count), 64'd0);
    set_mode(2'b10);
    clean(60, 30);
    drain();
    chk("prbs23_locked", 64'(locked), 64'd1);
    chk("prbs23_errors", 64'(error_count), 64'd0);

    // Build nonzero counts, then reset together with clear.
    set_mode(2'b11);
    clean(40, 0);
    garbage(4);
    clean(40, 0);
    next_word(w);
    send(w ^ msb_flip, 1'b1);
    drain();
    chk("pre_reset_locked", 64'(locked), 64'd1);
    reset = 1'b1; clear = 1'b1;
    gap();
    reset = 1'b0; clear = 1'b0;
    model_flush(); m_ec = 0; m_loss = 0;
    chk("rst_clr_locked", 64'(locked), 64'd0);
    chk("rst_clr_err_word", 64'(err_word), 64'd0);
    chk("rst_clr_error_count", 64'(error_count), 64'd0);
    chk("rst_clr_lock_loss", 64'(lock_loss_count), 64'd0);
    clean(17, 0);
    gap();
    chk("relock_after_reset", 64'(locked), 64'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
